sdram_port_arbiter: RTL and testbench

- Three-port round-robin arbiter that shares the single 32-bit SDRAM controller between requesters, e.g. instruction fetch, data load/store and DMA/video.
- Sits between the requesters and the controller's valid/ready interface: 25-bit byte address, 32-bit data, 4-bit write mask.
- Serialises accesses, latches the winning request, and routes read data and the completion pulse back to the owner.
- Handles the controller's ready quirks: ready is high out of reset, and completion is a one-cycle ready pulse.

---
 rtl/sdram_port_arbiter_if.sv | 37 +++
 rtl/sdram_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_sdram_port_arbiter.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_port_arbiter_if.sv
// Requester-side and controller-side valid/ready bundles
// used by the SDRAM port arbiter.
interface sdram_req_if;
   logic [24:0] addr;
   logic [31:0] din;
   logic [3:0]  wmask;
   logic        valid;
   logic [31:0] dout;
   logic        ready;

   modport master (
      output addr, din, wmask, valid,
      input  dout, ready
   );
   modport slave (
      input  addr, din, wmask, valid,
      output dout, ready
   );
endinterface

interface sdram_mem_if;
   logic [24:0] addr;
   logic [31:0] din;
   logic [3:0]  wmask;
   logic        valid;
   logic [31:0] dout;
   logic        ready;

   modport master (
      output addr, din, wmask, valid,
      input  dout, ready
   );
   modport slave (
      input  addr, din, wmask, valid,
      output dout, ready
   );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Three-port round-robin front end that serialises
// requests onto a single valid/ready SDRAM controller.
module sdram_port_arbiter #(
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int RESET_LAST     = 2
) (
   input  logic        clk,
   input  logic        reset,
   sdram_req_if.slave  p0,
   sdram_req_if.slave  p1,
   sdram_req_if.slave  p2,
   sdram_mem_if.master mem,
   output logic [1:0]  grant,
   output logic        err_timeout
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   state_e        state_q, state_d;
   logic [1:0]    last_q, last_d;
   logic          armed_q, armed_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
   logic [1:0]    grant_q, grant_d;
   logic          mvalid_q, mvalid_d;
   logic [24:0]   maddr_q, maddr_d;
   logic [31:0]   mdin_q, mdin_d;
   logic [3:0]    mwmask_q, mwmask_d;
   logic [31:0]   dout_q [3];
   logic [31:0]   dout_d [3];
   logic [2:0]    rdy_q, rdy_d;

   logic [2:0]    req;
   logic [24:0]   addr_a [3];
   logic [31:0]   din_a [3];
   logic [3:0]    wmask_a [3];
   logic          hit;
   logic [1:0]    pick;
   logic          done_hit;

   assign req        = {p2.valid, p1.valid, p0.valid};
   assign addr_a[0]  = p0.addr;
   assign addr_a[1]  = p1.addr;
   assign addr_a[2]  = p2.addr;
   assign din_a[0]   = p0.din;
   assign din_a[1]   = p1.din;
   assign din_a[2]   = p2.din;
   assign wmask_a[0] = p0.wmask;
   assign wmask_a[1] = p1.wmask;
   assign wmask_a[2] = p2.wmask;

   // A ready seen before the first low sample is the init/stale level.
   assign done_hit = mem.ready & armed_q;

   always_comb begin
      hit  = 1'b0;
      pick = 2'd0;
      for (int k = 1; k <= 3; k++) begin
         if (!hit && req[(int'(last_q) + k) % 3]) begin
            hit  = 1'b1;
            pick = 2'((int'(last_q) + k) % 3);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         last_q   <= 2'(RESET_LAST);
         armed_q  <= 1'b0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
         grant_q  <= 2'd3;
         mvalid_q <= 1'b0;
         maddr_q  <= '0;
         mdin_q   <= '0;
         mwmask_q <= '0;
         dout_q   <= '{default: '0};
         rdy_q    <= '0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         armed_q  <= armed_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
         grant_q  <= grant_d;
         mvalid_q <= mvalid_d;
         maddr_q  <= maddr_d;
         mdin_q   <= mdin_d;
         mwmask_q <= mwmask_d;
         dout_q   <= dout_d;
         rdy_q    <= rdy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      armed_d = armed_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      unique case (state_q)
         IDLE: begin
            if (hit) begin
               state_d = BUSY;
               last_d  = pick;
               armed_d = 1'b0;
               cnt_d   = '0;
            end
         end
         BUSY: begin
            if (cnt_q != TMAX) cnt_d = cnt_q + 1'b1;
            if (cnt_d == TMAX) err_d = 1'b1;
            if (!mem.ready) armed_d = 1'b1;
            if (done_hit) state_d = DONE;
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      grant_d  = grant_q;
      mvalid_d = mvalid_q;
      maddr_d  = maddr_q;
      mdin_d   = mdin_q;
      mwmask_d = mwmask_q;
      dout_d   = dout_q;
      rdy_d    = '0;
      unique case (state_q)
         IDLE: begin
            grant_d  = 2'd3;
            mvalid_d = 1'b0;
            if (hit) begin
               grant_d  = pick;
               mvalid_d = 1'b1;
               for (int i = 0; i < 3; i++) begin
                  if (pick == 2'(i)) begin
                     maddr_d  = addr_a[i];
                     mdin_d   = din_a[i];
                     mwmask_d = wmask_a[i];
                  end
               end
            end
         end
         BUSY: begin
            if (done_hit) begin
               grant_d  = 2'd3;
               mvalid_d = 1'b0;
               for (int i = 0; i < 3; i++) begin
                  if (grant_q == 2'(i)) begin
                     dout_d[i] = mem.dout;
                     rdy_d[i]  = 1'b1;
                  end
               end
            end
         end
         default: ;
      endcase
   end

   assign mem.addr    = maddr_q;
   assign mem.din     = mdin_q;
   assign mem.wmask   = mwmask_q;
   assign mem.valid   = mvalid_q;
   assign p0.dout     = dout_q[0];
   assign p1.dout     = dout_q[1];
   assign p2.dout     = dout_q[2];
   assign p0.ready    = rdy_q[0];
   assign p1.ready    = rdy_q[1];
   assign p2.ready    = rdy_q[2];
   assign grant       = grant_q;
   assign err_timeout = err_q;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: directed scenarios plus random
// traffic, all checked against a transaction-level model.
module tb_sdram_port_arbiter;
   localparam int T = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sdram_req_if p0 ();
   sdram_req_if p1 ();
   sdram_req_if p2 ();
   sdram_mem_if mem ();
   logic [1:0] grant;
   logic       err_timeout;

   sdram_port_arbiter #(
      .TIMEOUT_CYCLES(T),
      .RESET_LAST(2)
   ) dut (
      .clk(clk),
      .reset(reset),
      .p0(p0),
      .p1(p1),
      .p2(p2),
      .mem(mem),
      .grant(grant),
      .err_timeout(err_timeout)
   );

   logic [2:0]  rv = '0;
   logic [24:0] ra [3];
   logic [31:0] rd [3];
   logic [3:0]  rw [3];
   logic [31:0] o_dout [3];
   logic [2:0]  o_rdy;

   int          mmode = 0;
   int          mlat = 10;
   int          lat_cnt = 0;
   logic        man_ready = 1'b1;
   logic [31:0] man_dout = '0;
   logic        auto_ready = 1'b1;
   logic [31:0] auto_dout = '0;

   assign p0.valid = rv[0];
   assign p1.valid = rv[1];
   assign p2.valid = rv[2];
   assign p0.addr  = ra[0];
   assign p1.addr  = ra[1];
   assign p2.addr  = ra[2];
   assign p0.din   = rd[0];
   assign p1.din   = rd[1];
   assign p2.din   = rd[2];
   assign p0.wmask = rw[0];
   assign p1.wmask = rw[1];
   assign p2.wmask = rw[2];
   assign o_dout[0] = p0.dout;
   assign o_dout[1] = p1.dout;
   assign o_dout[2] = p2.dout;
   assign o_rdy = {p2.ready, p1.ready, p0.ready};
   assign mem.ready = (mmode == 0) ? man_ready : auto_ready;
   assign mem.dout  = (mmode == 0) ? man_dout : auto_dout;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Controller emulation: fixed latency or random ready.
   always @(negedge clk) begin
      if (mmode == 1) begin
         auto_dout = $urandom;
         if (mem.valid) begin
            lat_cnt++;
            auto_ready = (lat_cnt == mlat);
         end else begin
            lat_cnt = 0;
            auto_ready = 1'b1;
         end
      end else if (mmode == 2) begin
         auto_dout = $urandom;
         auto_ready = ($urandom_range(0, 3) == 0);
      end
   end

   // Transaction-level reference: one owner, a wait count,
   // whether ready was ever seen low, and a cool-down count.
   logic [1:0]  e_grant;
   logic        e_mv;
   logic [24:0] e_addr;
   logic [31:0] e_din;
   logic [3:0]  e_wm;
   logic        e_err;
   logic [2:0]  e_rdy;
   logic [31:0] e_dout [3];
   int own, waited, gap, ptr;
   bit low_seen;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         e_grant = 2'd3;
         e_mv = 1'b0;
         e_addr = '0;
         e_din = '0;
         e_wm = '0;
         e_err = 1'b0;
         e_rdy = '0;
         for (int i = 0; i < 3; i++) e_dout[i] = '0;
         own = 3;
         waited = 0;
         gap = 0;
         ptr = 2;
         low_seen = 1'b0;
      end else if (own != 3) begin
         if (waited < T) waited++;
         if (waited == T) e_err = 1'b1;
         if (mem.ready && low_seen) begin
            e_dout[own] = mem.dout;
            e_rdy[own] = 1'b1;
            e_mv = 1'b0;
            e_grant = 2'd3;
            own = 3;
            gap = 1;
         end else if (!mem.ready) begin
            low_seen = 1'b1;
         end
      end else if (gap > 0) begin
         gap--;
         e_rdy = '0;
      end else begin
         e_rdy = '0;
         for (int k = 1; k <= 3; k++) begin
            if (own == 3 && rv[(ptr + k) % 3]) begin
               own = (ptr + k) % 3;
            end
         end
         if (own != 3) begin
            ptr = own;
            e_grant = 2'(own);
            e_mv = 1'b1;
            e_addr = ra[own];
            e_din = rd[own];
            e_wm = rw[own];
            waited = 0;
            low_seen = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("grant", 32'(grant), 32'(e_grant));
         chk("mem_valid", 32'(mem.valid), 32'(e_mv));
         chk("mem_addr", 32'(mem.addr), 32'(e_addr));
         chk("mem_din", mem.din, e_din);
         chk("mem_wmask", 32'(mem.wmask), 32'(e_wm));
         chk("err_timeout", 32'(err_timeout), 32'(e_err));
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("p%0d_ready", i), 32'(o_rdy[i]), 32'(e_rdy[i]));
            chk($sformatf("p%0d_dout", i), o_dout[i], e_dout[i]);
         end
      end
   end

   task automatic tick(int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      #1 reset = 1'b1;
      rv = '0;
      mmode = 0;
      man_ready = 1'b1;
      man_dout = '0;
      for (int i = 0; i < 3; i++) begin
         ra[i] = '0;
         rd[i] = '0;
         rw[i] = '0;
      end
      tick(2);
      reset = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: run did not end, want finish");
      n_bad++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int grants[$];
      int exp_seq[6] = '{0, 1, 2, 0, 1, 2};
      bit flag;
      bit prev;
      int pulses;
      bit seen;

      // Reset values, then a read under the ready-high init quirk.
      do_reset();
      chk("rst_grant", 32'(grant), 32'd3);
      chk("rst_mem_valid", 32'(mem.valid), 32'd0);
      chk("rst_err", 32'(err_timeout), 32'd0);
      chk("rst_p0_dout", o_dout[0], 32'd0);
      rv[0] = 1'b1;
      ra[0] = 25'h0000100;
      tick();
      chk("t1_mem_valid", 32'(mem.valid), 32'd1);
      chk("t1_grant", 32'(grant), 32'd0);
      chk("t1_mem_addr", 32'(mem.addr), 32'h100);
      flag = 1'b0;
      repeat (49) begin
         tick();
         if (o_rdy[0]) flag = 1'b1;
      end
      chk("t1_no_early_ready", 32'(flag), 32'd0);
      man_ready = 1'b0;
      tick();
      man_ready = 1'b1;
      man_dout = 32'h12345678;
      tick();
      chk("t1_p0_ready", 32'(o_rdy[0]), 32'd1);
      chk("t1_p0_dout", o_dout[0], 32'h12345678);
      rv[0] = 1'b0;
      tick();
      chk("t1_ready_one_cycle", 32'(o_rdy[0]), 32'd0);

      // All three ports requesting continuously.
      do_reset();
      mmode = 1;
      mlat = 10;
      rv = 3'b111;
      ra[1] = 25'h10;
      ra[2] = 25'h20;
      prev = 1'b0;
      for (int c = 0; c < 300 && grants.size() < 6; c++) begin
         tick();
         if (mem.valid && !prev) grants.push_back(int'(grant));
         prev = mem.valid;
      end
      chk("t2_grant_count", 32'(grants.size()), 32'd6);
      for (int i = 0; i < 6 && i < grants.size(); i++)
         chk($sformatf("t2_grant_seq%0d", i), 32'(grants[i]), 32'(exp_seq[i]));
      rv = '0;
      tick(20);

      // Write on p1 with requester-side churn while busy.
      do_reset();
      mmode = 1;
      mlat = 8;
      rv[1] = 1'b1;
      ra[1] = 25'h1FFFFFC;
      rd[1] = 32'hA5A5_5A5A;
      rw[1] = 4'hF;
      tick();
      chk("t3_mem_valid", 32'(mem.valid), 32'd1);
      ra[1] = 25'h0000004;
      rd[1] = 32'h0;
      rw[1] = 4'h0;
      flag = 1'b1;
      pulses = 0;
      repeat (20) begin
         if (mem.valid && (mem.addr != 25'h1FFFFFC ||
             mem.din != 32'hA5A5_5A5A || mem.wmask != 4'hF))
            flag = 1'b0;
         if (o_rdy[1]) begin
            pulses++;
            rv[1] = 1'b0;
         end
         tick();
      end
      chk("t3_held_stable", 32'(flag), 32'd1);
      chk("t3_p1_pulses", 32'(pulses), 32'd1);

      // Timeout: ready held low for 40 cycles.
      do_reset();
      man_ready = 1'b0;
      rv[0] = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (k == 16) chk("t4_err_before", 32'(err_timeout), 32'd0);
         if (k == 17) chk("t4_err_after", 32'(err_timeout), 32'd1);
      end
      man_ready = 1'b1;
      man_dout = 32'hCAFE_F00D;
      tick();
      chk("t4_p0_ready", 32'(o_rdy[0]), 32'd1);
      chk("t4_p0_dout", o_dout[0], 32'hCAFE_F00D);
      rv[0] = 1'b0;
      tick();
      chk("t4_err_sticky", 32'(err_timeout), 32'd1);

      // Asynchronous reset in the middle of a p2 access.
      do_reset();
      man_ready = 1'b0;
      rv[2] = 1'b1;
      tick(20);
      chk("t5_grant_pre", 32'(grant), 32'd2);
      chk("t5_err_pre", 32'(err_timeout), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("t5_rst_mem_valid", 32'(mem.valid), 32'd0);
      chk("t5_rst_grant", 32'(grant), 32'd3);
      chk("t5_rst_err", 32'(err_timeout), 32'd0);
      rv = 3'b101;
      tick();
      reset = 1'b0;
      tick();
      chk("t5_p0_first", 32'(grant), 32'd0);

      // p0 abandons its request while p1 is being served.
      do_reset();
      mmode = 1;
      mlat = 6;
      rv[1] = 1'b1;
      tick();
      rv[0] = 1'b1;
      tick(2);
      rv[0] = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
         tick();
         if (o_rdy[1]) begin
            seen = 1'b1;
            rv[1] = 1'b0;
         end
      end
      chk("t6_p1_done", 32'(seen), 32'd1);
      flag = 1'b0;
      repeat (10) begin
         tick();
         if (mem.valid) flag = 1'b1;
      end
      chk("t6_stays_idle", 32'(flag), 32'd0);

      // Random traffic against the model.
      do_reset();
      mmode = 2;
      repeat (3000) begin
         for (int i = 0; i < 3; i++) begin
            if (o_rdy[i]) begin
               rv[i] = 1'b0;
            end else if (!rv[i]) begin
               if ($urandom_range(0, 3) == 0) begin
                  rv[i] = 1'b1;
                  ra[i] = 25'($urandom);
                  rd[i] = $urandom;
                  rw[i] = ($urandom_range(0, 1) == 1) ?
                          4'($urandom) : 4'd0;
               end
            end else begin
               if ($urandom_range(0, 3) == 0) ra[i] = 25'($urandom);
               if ($urandom_range(0, 3) == 0) rd[i] = $urandom;
               if ($urandom_range(0, 31) == 0) rv[i] = 1'b0;
            end
         end
         tick();
      end
      rv = '0;
      tick(40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
